imem_uart_loader: RTL
=====================

// Module: imem_uart_loader
// PURPOSE
//  Writer side of the instruction-memory interface read by the fetch unit. It
//  assembles a byte stream from the UART receiver into 32-bit words and writes
//  them into the program ROM's write port at consecutive word addresses.
//  While loading, it holds the CPU so that no fetch runs against a half-written
//  program. It is the download path that puts programs on the board without
//  regenerating the bitstream.
// PARAMETERS
//  ADDR_W   14         word-address width; matches the 14-bit fetch address PC[15:2]
//  TIMEOUT  1000000    max idle clocks between accepted bytes while loading
// PORTS
//  clock          in   1         system clock; all state updates on posedge
//  reset          in   1         reset, asynchronous, active-high
//  start          in   1         single-cycle pulse that begins a load session
//  rx_valid       in   1         rx_data valid this cycle (1-cycle strobe per byte)
//  rx_data        in   8         received byte
//  imem_we        out  1         instruction-memory write enable (1-cycle pulse)
//  imem_addr      out  ADDR_W    word address of the write
//  imem_wdata     out  32        instruction word to write
//  cpu_hold       out  1         1 = keep CPU/fetch PC in reset
//  done           out  1         load completed successfully (level)
//  error          out  1         load aborted (level)
//  words_written  out  ADDR_W+1  count of words written this session
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; byte counter, word counter and timer cleared.
//  Stream format: LEN_HI, LEN_LO (N = 16-bit word count, big-endian), then N*4
//   bytes. Each word is big-endian: the first byte goes to [31:24].
//  States: IDLE, LEN_HI, LEN_LO, DATA, FIN, DONE, ERR.
//  - IDLE/DONE/ERR: when start=1, go to LEN_HI. This clears done, error and
//    words_written and sets cpu_hold=1. rx_valid is ignored in these states.
//  - LEN_HI: a byte loads N[15:8] and moves to LEN_LO.
//  - LEN_LO: a byte loads N[7:0]. Then:
//      N==0         -> FIN
//      N>2**ADDR_W  -> ERR
//      otherwise    -> DATA
//  - DATA: bytes shift into a word register; a 2-bit byte index tracks position.
//    On the edge that accepts byte 3 of a word:
//      imem_we=1 in the following cycle only;
//      imem_addr = current word index (0-based);
//      imem_wdata = the assembled word.
//    The word index and words_written increment on the same edge that drops
//    imem_we. If the word was the Nth, the state goes to FIN on the edge that
//    asserts imem_we.
//  - Back-to-back rx_valid, one byte per cycle, is legal in DATA; no byte is lost.
//  - FIN: lasts one cycle, then DONE. DONE: done=1, cpu_hold=0.
//    cpu_hold therefore drops at least 1 cycle after the last imem_we pulse.
//  - ERR: error=1 and cpu_hold stays 1, so a partial program never runs.
//    Only start or reset leaves ERR.
//  Timeout: in LEN_HI, LEN_LO and DATA, a timer clears on every accepted byte and
//   otherwise increments. When it reaches TIMEOUT-1, the state goes to ERR.
//  start while in LEN_HI, LEN_LO, DATA or FIN is ignored.
//  imem_we never asserts outside the cycle after a word completes.
//  imem_addr and imem_wdata hold their last values when imem_we=0.
//  Reset mid-session: an immediate asynchronous return to IDLE with cpu_hold=0.
//   Words already written stay in memory; no further writes occur.
//  The word index wraps only with N==2**ADDR_W. The last address is then
//   2**ADDR_W-1 and no wrap write occurs.
// TESTING
//  1. start; bytes 00 02 12 34 56 78 9A BC DE F0 -> we pulses:
//     addr 0 = 0x12345678, then addr 1 = 0x9ABCDEF0; done=1 2 cycles after the
//     last byte; words_written=2; cpu_hold 1->0.
//  2. start; bytes 00 00 -> no imem_we; FIN then DONE; done=1; words_written=0.
//  3. start; 00 01 AA BB then silence (TIMEOUT=16) -> error=1 after 16 idle
//     cycles, cpu_hold=1, no imem_we.
//  4. ADDR_W=4; start; 00 11 (N=17 > 16) -> error=1 immediately after LEN_LO;
//     a new start then recovers with a good stream.
//  5. rx_valid every cycle for 00 03 + 12 bytes -> 3 writes at addr 0,1,2 with
//     correct data; a start pulse mid-stream has no effect.
//  6. Assert reset after 6 data bytes -> all outputs 0 within the reset cycle,
//     state IDLE; the next session writes from addr 0.

Source files
------------

// File: rtl/imem_uart_loader_if.sv
// Loader-side bus: UART byte strobe in, instruction-memory write port out.
// The master modport is the loader itself; slave is the UART/ROM side.
interface imem_uart_loader_if #(
   parameter int ADDR_W = 14
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      input  rx_valid,
      input  rx_data,
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      output rx_valid,
      output rx_data,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata
   );
endinterface

// File: rtl/imem_uart_loader.sv
// Assembles a length-prefixed big-endian UART byte stream into 32-bit words and
// writes them to the program ROM while holding the CPU in reset.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no session since reset; waiting for start
// S_LEN_HI | waiting for word-count high byte
// S_LEN_LO | waiting for word-count low byte; range-checks the count
// S_DATA   | collecting payload bytes, one ROM write per 4 bytes
// S_FIN    | one-cycle gap so cpu_hold drops after the last write
// S_DONE   | load complete, CPU released; waiting for start
// S_ERR    | load aborted, CPU kept held; waiting for start
module imem_uart_loader #(
   parameter int ADDR_W  = 14,
   parameter int TIMEOUT = 1000000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   imem_uart_loader_if.master  bus,
   output logic                cpu_hold,
   output logic                done,
   output logic                error,
   output logic [ADDR_W:0]     words_written
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_FIN,
      S_DONE,
      S_ERR
   } state_t;

   localparam int TMR_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(TIMEOUT - 1);
   localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);

   state_t            state;
   logic [15:0]       len;
   logic [23:0]       shift;
   logic [1:0]        byte_idx;
   logic [ADDR_W-1:0] word_idx;
   logic [TMR_W-1:0]  tmr;

   logic [15:0] len_next;
   logic        last_word;
   logic        timed;

   assign len_next  = {len[15:8], bus.rx_data};
   assign last_word = ({1'b0, len} == (17'(words_written) + 17'd1));
   assign timed     = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         len            <= '0;
         shift          <= '0;
         byte_idx       <= '0;
         word_idx       <= '0;
         tmr            <= '0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         cpu_hold       <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
         words_written  <= '0;
      end else begin
         // The write pulse is retired and counted one cycle after it is raised.
         if (bus.imem_we) begin
            bus.imem_we   <= 1'b0;
            word_idx      <= word_idx + 1'b1;
            words_written <= words_written + 1'b1;
         end

         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state         <= S_LEN_HI;
                  done          <= 1'b0;
                  error         <= 1'b0;
                  cpu_hold      <= 1'b1;
                  words_written <= '0;
                  word_idx      <= '0;
                  byte_idx      <= '0;
                  tmr           <= TMR_LOAD;
               end
            end
            S_LEN_HI: begin
               if (bus.rx_valid) begin
                  len[15:8] <= bus.rx_data;
                  tmr       <= TMR_LOAD;
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (bus.rx_valid) begin
                  len[7:0] <= bus.rx_data;
                  tmr      <= TMR_LOAD;
                  if (len_next == 16'd0) begin
                     state <= S_FIN;
                  end else if ({1'b0, len_next} > MAX_WORDS) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (bus.rx_valid) begin
                  tmr      <= TMR_LOAD;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_addr  <= word_idx;
                     bus.imem_wdata <= {shift, bus.rx_data};
                     if (last_word) begin
                        state <= S_FIN;
                     end
                  end else begin
                     shift <= {shift[15:0], bus.rx_data};
                  end
               end
            end
            S_FIN: begin
               state    <= S_DONE;
               done     <= 1'b1;
               cpu_hold <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         // Idle-gap watchdog: reloaded on every accepted byte, expires at zero.
         if (timed && !bus.rx_valid) begin
            if (tmr == '0) begin
               state <= S_ERR;
               error <= 1'b1;
            end else begin
               tmr <= tmr - 1'b1;
            end
         end
      end
   end

endmodule
